// File: rtl/alu_muldiv.sv
// alu_muldiv -- width-parametrised MIPS execution ALU with iterative mult/div.
//
// Single-cycle ops (add/sub/logic/shift/slt/mthi/mtlo/mfhi/mflo) register their
// result on the accepting edge and pulse done for the following cycle.
// MULT/MULTU (shift-add) and DIV/DIVU (restoring) iterate one bit per cycle,
// hold busy for WIDTH cycles, then write HI/LO and pulse done.
//
// Configuration macro: ALU_DIV_EN -- when defined the divider datapath and DIV
// state are built; otherwise funct 26/27 behave as an unknown funct.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               issue an op (ignored while busy)
//   control_bus[1:0]    00 add, 01 sub, 10 decode funct, 11 out=0
//   funct[5:0]          R-type function field
//   shamt[SHAMT_W-1:0]  shift amount
//   a, b                operands (rs, rt)
//   out, zero           registered result and (out == 0)
//   hi, lo              architectural HI/LO
//   busy, done          mult/div in flight; one-cycle completion pulse
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         control_bus,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   out,
  output logic               zero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               done
);
  localparam int CNT_W = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_e;

  // Magnitude of x when treated as signed (sgn=1), else x unchanged.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (WIDTH'(0) - x) : x;
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d, hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;       // negate product / quotient at the end

  // Multiplier: {sum, multiplier} shifts right one bit per step.
  logic [2*WIDTH:0]   prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_nxt;
  logic [2*WIDTH-1:0] mul_res;

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, dvnd_q, dvnd_d;
  logic               rneg_q, rneg_d, div0_q, div0_d;
  logic [WIDTH:0]     div_sh, div_df;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem, div_quo;
`endif

  logic             accept, op_r, op_mul, op_div;
  logic [WIDTH-1:0] res;

  assign accept = start && (state_q == S_IDLE);
  assign op_r   = (control_bus == 2'b10);
  assign op_mul = op_r && (funct == 6'd24 || funct == 6'd25);
`ifdef ALU_DIV_EN
  assign op_div = op_r && (funct == 6'd26 || funct == 6'd27);
`else
  assign op_div = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && op_mul)      state_d = S_MUL;
        else if (accept && op_div) state_d = S_DIV;
      end
      S_MUL, S_DIV: if (cnt_q == LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    out  = out_q;
    hi   = hi_q;
    lo   = lo_q;
    zero = (out_q == '0);
  end

  // Single-cycle result
  always_comb begin
    res = '0;
    case (control_bus)
      2'b00: res = a + b;
      2'b01: res = a - b;
      2'b10: begin
        case (funct)
          6'd32: res = a + b;
          6'd34: res = a - b;
          6'd36: res = a & b;
          6'd37: res = a | b;
          6'd39: res = ~(a | b);
          6'd0:  res = b << shamt;
          6'd2:  res = b >> shamt;
          6'd3:  res = $signed(b) >>> shamt;
          6'd42: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          6'd43: res = {{(WIDTH-1){1'b0}}, (a < b)};
          6'd17, 6'd19: res = a;
          6'd16: res = hi_q;
          6'd18: res = lo_q;
          default: res = '0;
        endcase
      end
      default: res = '0;
    endcase
  end

  // Datapath next values
  always_comb begin
    out_d   = out_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;

    mul_sum = prod_q[2*WIDTH:WIDTH] + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_nxt = {mul_sum, prod_q[WIDTH-1:0]} >> 1;
    mul_res = neg_q ? ((2*WIDTH)'(0) - mul_nxt[2*WIDTH-1:0]) : mul_nxt[2*WIDTH-1:0];

`ifdef ALU_DIV_EN
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    dvnd_d  = dvnd_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    // Restoring step: shift in next dividend bit, subtract if it fits.
    div_sh  = {rem_q, quo_q[WIDTH-1]};
    div_df  = div_sh - {1'b0, dvsr_q};
    div_ok  = !div_df[WIDTH];
    div_rem = div_ok ? div_df[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_quo = {quo_q[WIDTH-2:0], div_ok};
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (op_mul) begin
            mcand_d = mag(a, funct == 6'd24);
            prod_d  = {(WIDTH+1)'(0), mag(b, funct == 6'd24)};
            neg_d   = (funct == 6'd24) && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_DIV_EN
          end else if (op_div) begin
            quo_d  = mag(a, funct == 6'd26);
            dvsr_d = mag(b, funct == 6'd26);
            rem_d  = '0;
            dvnd_d = a;
            neg_d  = (funct == 6'd26) && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d = (funct == 6'd26) && a[WIDTH-1];
            div0_d = (b == '0);
`endif
          end else begin
            out_d  = res;
            done_d = 1'b1;
            if (op_r && funct == 6'd17) hi_d = a;
            if (op_r && funct == 6'd19) lo_d = a;
          end
        end
      end
      S_MUL: begin
        prod_d = mul_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          hi_d   = mul_res[2*WIDTH-1:WIDTH];
          lo_d   = mul_res[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        rem_d = div_rem;
        quo_d = div_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // Divide by zero overrides the datapath: quotient all ones, remainder = a.
          if (div0_q) begin
            lo_d = '1;
            hi_d = dvnd_q;
          end else begin
            lo_d = neg_q  ? (WIDTH'(0) - div_quo) : div_quo;
            hi_d = rneg_q ? (WIDTH'(0) - div_rem) : div_rem;
          end
          done_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      mcand_q <= '0;
`ifdef ALU_DIV_EN
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      dvnd_q  <= '0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
`endif
    end else begin
      out_q   <= out_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
`ifdef ALU_DIV_EN
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
`endif
    end
  end

endmodule
